// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - byte-wide memory bus arbiter between ICache fetches and LSB loads/stores
//
// Purpose: grants the external byte bus to the ICache (fixed-size word fetches)
// or the LSB (1/2/4-byte loads and stores), sequences the grant into byte beats,
// assembles little-endian read data and pulses a one-cycle done to the owner.
//
// Configuration: define MEM_ARB_FAIR_EN for round-robin arbitration on
// contention; otherwise the LSB has fixed priority.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   rdy                global ready; low freezes all state
//   rollback           misprediction flush (aborts reads only)
//   mem_din/mem_dout   read byte (one cycle after address) / write byte
//   mem_a/mem_wr       byte address / write strobe
//   io_buffer_full     UART full; stalls write beats to the IO window
//   ic_req/ic_addr     ICache fetch request and word address
//   ic_done/ic_data    fetch completion pulse and fetched word
//   ls_req/ls_wr/ls_addr/ls_len/ls_wdata   LSB request
//   ls_done/ls_rdata   LSB completion pulse and zero-extended load data

module mem_bus_arbiter #(
    parameter int IC_BYTES = 4,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_done,
    output logic [31:0]       ic_data,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [2:0]        ls_len,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_last_ls;   // last grant went to the LSB
    logic              r_own_ls;    // current transaction belongs to the LSB
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_data;
    logic [2:0]        r_cnt;
    logic [2:0]        r_len;
    logic [ADDR_W-1:0] r_a_hold;    // last driven address, replayed while rdy is low

    logic              w_grant_ls;
    logic [2:0]        w_ls_len_n;
    logic              w_beat_active;
    logic [ADDR_W-1:0] w_beat_addr;
    logic              w_io_stall;
    logic [1:0]        w_lane;

    always_comb begin
`ifdef MEM_ARB_FAIR_EN
        w_grant_ls = ls_req && (!ic_req || !r_last_ls);
`else
        w_grant_ls = ls_req;
`endif
    end

    assign w_ls_len_n    = (ls_len == 3'd1) ? 3'd1 : (ls_len == 3'd2) ? 3'd2 : 3'd4;
    assign w_beat_active = ((r_state == S_READ) || (r_state == S_WRITE)) && (r_cnt < r_len);
    assign w_beat_addr   = r_addr + ADDR_W'(r_cnt);
    assign w_io_stall    = (r_state == S_WRITE) && (w_beat_addr[17:16] == 2'b11) && io_buffer_full;
    // Capture lane trails the beat counter by one; cnt==4 wraps to lane 3.
    assign w_lane        = r_cnt[1:0] - 2'd1;

    // Holding mem_a during a freeze keeps mem_din returning the byte of the
    // last issued beat, so capture stays aligned when rdy comes back.
    assign mem_a    = rdy ? (w_beat_active ? w_beat_addr : '0) : r_a_hold;
    assign mem_wr   = rdy && (r_state == S_WRITE) && w_beat_active && !w_io_stall;
    assign mem_dout = ((r_state == S_WRITE) && w_beat_active) ? r_wdata[{r_cnt[1:0], 3'b000} +: 8] : 8'h00;
    assign ic_done  = (r_state == S_DONE) && !r_own_ls;
    assign ls_done  = (r_state == S_DONE) && r_own_ls;
    assign ic_data  = r_data;
    assign ls_rdata = r_data;

    always_comb begin
        w_next = r_state;
        if (rdy) begin
            case (r_state)
                S_IDLE: begin
                    if (ic_req || ls_req) begin
                        w_next = (w_grant_ls && ls_wr) ? S_WRITE : S_READ;
                    end
                end
                S_READ: begin
                    if (rollback) begin
                        w_next = S_IDLE;
                    end else if (r_cnt == r_len) begin
                        w_next = S_DONE;
                    end
                end
                S_WRITE: begin
                    if (!w_io_stall && (r_cnt == r_len - 3'd1)) begin
                        w_next = S_DONE;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_ls <= 1'b0;
            r_own_ls  <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_data    <= '0;
            r_cnt     <= '0;
            r_len     <= '0;
            r_a_hold  <= '0;
        end else begin
            r_a_hold <= mem_a;
            if (rdy) begin
                case (r_state)
                    S_IDLE: begin
                        if (ic_req || ls_req) begin
                            r_own_ls  <= w_grant_ls;
                            r_last_ls <= w_grant_ls;
                            r_addr    <= w_grant_ls ? ls_addr : ic_addr;
                            r_len     <= w_grant_ls ? w_ls_len_n : 3'(IC_BYTES);
                            r_wdata   <= ls_wdata;
                            r_cnt     <= '0;
                            r_data    <= '0;
                        end
                    end
                    S_READ: begin
                        if (rollback) begin
                            r_data <= '0;
                        end else begin
                            if (r_cnt != 3'd0) begin
                                r_data[{w_lane, 3'b000} +: 8] <= mem_din;
                            end
                            if (r_cnt != r_len) begin
                                r_cnt <= r_cnt + 3'd1;
                            end
                        end
                    end
                    S_WRITE: begin
                        if (!w_io_stall) begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter

module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        rollback;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_done;
    logic [31:0] ic_data;
    logic        ls_req;
    logic        ls_wr;
    logic [31:0] ls_addr;
    logic [2:0]  ls_len;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [0:4095];

    mem_bus_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_data(ic_data),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_len(ls_len),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_din <= mem[mem_a[11:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of clock edges until the wanted done pulse, 0 on timeout.
    task automatic wait_done(input bit want_ls, input string tag, output int cyc);
        cyc = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            #1;
            if (want_ls ? ls_done : ic_done) begin
                cyc = k;
                break;
            end
        end
        if (cyc == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s timeout observed=no_done expected=done", tag);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int  cyc;
        bit  first_ls;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h100] = 8'h13; mem[12'h101] = 8'h00; mem[12'h102] = 8'h00; mem[12'h103] = 8'h93;
        mem[12'h300] = 8'h5A; mem[12'h301] = 8'hC3;

        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
        ic_req = 1'b0; ic_addr = '0; ls_req = 1'b0; ls_wr = 1'b0;
        ls_addr = '0; ls_len = 3'd0; ls_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
        chk("rst_mem_dout", {24'b0, mem_dout}, 32'h0);
        chk("rst_ic_done", {31'b0, ic_done}, 32'h0);
        chk("rst_ls_done", {31'b0, ls_done}, 32'h0);
        chk("rst_ic_data", ic_data, 32'h0);
        chk("rst_ls_rdata", ls_rdata, 32'h0);
        rst = 1'b0;

        // ICache fetch: 4 beats, done 5 cycles after beat 0
        step(); ic_req = 1'b1; ic_addr = 32'h100; #1;
        chk("t1_idle_mem_a", mem_a, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            chk("t1_beat_addr", mem_a, 32'h100 + i);
            chk("t1_beat_wr", {31'b0, mem_wr}, 32'h0);
            chk("t1_beat_nodone", {31'b0, ic_done}, 32'h0);
        end
        step(); #1;
        chk("t1_capture_mem_a", mem_a, 32'h0);
        chk("t1_capture_nodone", {31'b0, ic_done}, 32'h0);
        step(); #1;
        chk("t1_ic_done", {31'b0, ic_done}, 32'h1);
        chk("t1_ic_data", ic_data, 32'h93000013);
        chk("t1_ls_done_low", {31'b0, ls_done}, 32'h0);
        step(); ic_req = 1'b0; #1;
        chk("t1_done_one_cycle", {31'b0, ic_done}, 32'h0);

        // 2-byte store
        step(); ls_req = 1'b1; ls_wr = 1'b1; ls_addr = 32'h200; ls_len = 3'd2; ls_wdata = 32'h0000BEEF; #1;
        step(); #1;
        chk("t2_b0_addr", mem_a, 32'h200);
        chk("t2_b0_dout", {24'b0, mem_dout}, 32'hEF);
        chk("t2_b0_wr", {31'b0, mem_wr}, 32'h1);
        step(); #1;
        chk("t2_b1_addr", mem_a, 32'h201);
        chk("t2_b1_dout", {24'b0, mem_dout}, 32'hBE);
        chk("t2_b1_wr", {31'b0, mem_wr}, 32'h1);
        step(); #1;
        chk("t2_ls_done", {31'b0, ls_done}, 32'h1);
        chk("t2_done_wr", {31'b0, mem_wr}, 32'h0);
        step(); ls_req = 1'b0; ls_wr = 1'b0; #1;

        // Contention: ICache fetch at 0x100 and LSB 1-byte load at 0x300
`ifdef MEM_ARB_FAIR_EN
        first_ls = 1'b0;
`else
        first_ls = 1'b1;
`endif
        step(); ic_req = 1'b1; ic_addr = 32'h100;
        ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 32'h300; ls_len = 3'd1; #1;
        step(); #1;
        chk("t3_first_beat", mem_a, first_ls ? 32'h300 : 32'h100);
        wait_done(first_ls, "t3_first_done", cyc);
        chk("t3_first_latency", cyc, first_ls ? 32'd2 : 32'd5);
        chk("t3_first_data", first_ls ? ls_rdata : ic_data, first_ls ? 32'h0000005A : 32'h93000013);
        step();
        if (first_ls) ls_req = 1'b0; else ic_req = 1'b0;
        #1;
        wait_done(!first_ls, "t3_second_done", cyc);
        chk("t3_second_latency", cyc, first_ls ? 32'd6 : 32'd3);
        chk("t3_second_data", first_ls ? ic_data : ls_rdata, first_ls ? 32'h93000013 : 32'h0000005A);
        step(); ic_req = 1'b0; ls_req = 1'b0; #1;

        // Rollback at beat 2 of a fetch, LSB load pending
        step(); ic_req = 1'b1; ic_addr = 32'h100; #1;
        step(); #1;
        chk("t4_b0", mem_a, 32'h100);
        step(); #1;
        step(); rollback = 1'b1; ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 32'h300; ls_len = 3'd2; #1;
        chk("t4_b2", mem_a, 32'h102);
        step(); rollback = 1'b0; ic_req = 1'b0; #1;
        chk("t4_idle_mem_a", mem_a, 32'h0);
        chk("t4_no_ic_done", {31'b0, ic_done}, 32'h0);
        wait_done(1'b1, "t4_ls_done", cyc);
        chk("t4_ls_latency", cyc, 32'd4);
        chk("t4_ls_rdata", ls_rdata, 32'h0000C35A);
        step(); ls_req = 1'b0; #1;

        // IO store stalled by a full UART buffer
        step(); ls_req = 1'b1; ls_wr = 1'b1; ls_addr = 32'h30000; ls_len = 3'd1;
        ls_wdata = 32'h41; io_buffer_full = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            chk("t5_stall_wr", {31'b0, mem_wr}, 32'h0);
            chk("t5_stall_nodone", {31'b0, ls_done}, 32'h0);
        end
        step(); io_buffer_full = 1'b0; #1;
        chk("t5_release_wr", {31'b0, mem_wr}, 32'h1);
        chk("t5_release_addr", mem_a, 32'h30000);
        chk("t5_release_dout", {24'b0, mem_dout}, 32'h41);
        step(); #1;
        chk("t5_ls_done", {31'b0, ls_done}, 32'h1);
        chk("t5_single_beat", {31'b0, mem_wr}, 32'h0);
        step(); ls_req = 1'b0; ls_wr = 1'b0; #1;

        // rdy low for 2 cycles during a 4-byte load
        step(); ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 32'h100; ls_len = 3'd4; #1;
        step(); #1;
        chk("t6_b0", mem_a, 32'h100);
        step(); #1;
        chk("t6_b1", mem_a, 32'h101);
        for (int i = 0; i < 2; i++) begin
            step(); rdy = 1'b0; #1;
            chk("t6_frozen_addr", mem_a, 32'h101);
            chk("t6_frozen_wr", {31'b0, mem_wr}, 32'h0);
        end
        step(); rdy = 1'b1; #1;
        chk("t6_b2", mem_a, 32'h102);
        wait_done(1'b1, "t6_ls_done", cyc);
        chk("t6_latency_rest", cyc, 32'd3);
        chk("t6_ls_rdata", ls_rdata, 32'h93000013);
        step(); ls_req = 1'b0; #1;

        // Illegal length 3 behaves as 4
        step(); ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 32'h100; ls_len = 3'd3; #1;
        wait_done(1'b1, "t7_ls_done", cyc);
        chk("t7_latency", cyc, 32'd6);
        chk("t7_ls_rdata", ls_rdata, 32'h93000013);
        step(); ls_req = 1'b0; #1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
